// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB stage of the RV32I pipeline.
//   WB_SEL_*  : write-back source select encodings (2 bits)
//   F3_*      : load funct3 encodings (3 bits)
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension (purely combinational).
// Ports:
//   rdata_i   : raw 32-bit word read from data memory
//   funct3_i  : load type (LB/LH/LW/LBU/LHU, anything else treated as LW)
//   addr_lo_i : byte offset of the load address
//   data_o    : extended value to write back
module load_extend
    import wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // Halfword offset bit 0 is ignored; misalignment is not detected here.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back logic for the 5-stage RV32I core.
// Outputs are driven from registered state only (1-cycle latency).
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   stall, flush     : hazard-unit hold / bubble (flush has priority)
//   in_*             : MEM-stage results and load control
//   RegWrite, WriteAddr, WriteData : register-file write port
//   wb_valid         : a valid instruction occupies WB
//   retire_cnt       : 64-bit retired-instruction counter, present only when
//                      WB_RETIRE_CNT_EN is defined
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_reg_write,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_pc_plus4,
    output logic            RegWrite,
    output logic [4:0]      WriteAddr,
    output logic [XLEN-1:0] WriteData,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     retire_cnt,
`endif
    output logic            wb_valid
);

    logic            valid_q,     valid_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q,        rd_d;
    logic [1:0]      wb_sel_q,    wb_sel_d;
    logic [2:0]      funct3_q,    funct3_d;
    logic [1:0]      addr_lo_q,   addr_lo_d;
    logic [XLEN-1:0] alu_q,       alu_d;
    logic [XLEN-1:0] rdata_q,     rdata_d;
    logic [XLEN-1:0] pc4_q,       pc4_d;
    logic [XLEN-1:0] load_data;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        wb_sel_d    = wb_sel_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        if (flush) begin
            // Bubble; payload cleared too so the outputs are deterministic.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            wb_sel_d    = '0;
            funct3_d    = '0;
            addr_lo_d   = '0;
            alu_d       = '0;
            rdata_d     = '0;
            pc4_d       = '0;
        end else if (!stall) begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write & in_valid;
            rd_d        = in_rd;
            wb_sel_d    = in_wb_sel;
            funct3_d    = in_funct3;
            addr_lo_d   = in_addr_lo;
            alu_d       = in_alu_result;
            rdata_d     = in_mem_rdata;
            pc4_d       = in_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wb_sel_q    <= wb_sel_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
        end
    end

    load_extend u_load_extend (
        .rdata_i   (rdata_q),
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .data_o    (load_data)
    );

    always_comb begin
        case (wb_sel_q)
            WB_SEL_MEM: WriteData = load_data;
            WB_SEL_PC4: WriteData = pc4_q;
            WB_SEL_ALU: WriteData = alu_q;
            default:    WriteData = alu_q;  // reserved encoding behaves as ALU
        endcase
    end

    // x0 is hard-wired zero, so writes to it are suppressed here.
    assign RegWrite  = valid_q & reg_write_q & (rd_q != 5'd0);
    assign WriteAddr = rd_q;
    assign wb_valid  = valid_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (in_valid && !stall && !flush) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage. Retire counter checks are
// compiled in when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        wb_valid;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_pc_plus4   (in_pc_plus4),
        .RegWrite      (RegWrite),
        .WriteAddr     (WriteAddr),
        .WriteData     (WriteData),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt    (retire_cnt),
`endif
        .wb_valid      (wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        exp_rw;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic v, logic rw, logic [4:0] rd, logic [1:0] sel,
                                logic [2:0] f3, logic [1:0] alo, logic [31:0] alu,
                                logic [31:0] rdata, logic [31:0] pc4, logic erw,
                                logic [31:0] edata);
        vec_t t;
        t.valid = v; t.reg_write = rw; t.rd = rd; t.wb_sel = sel; t.funct3 = f3;
        t.addr_lo = alo; t.alu = alu; t.rdata = rdata; t.pc4 = pc4;
        t.exp_rw = erw; t.exp_data = edata;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid      = t.valid;
        in_reg_write  = t.reg_write;
        in_rd         = t.rd;
        in_wb_sel     = t.wb_sel;
        in_funct3     = t.funct3;
        in_addr_lo    = t.addr_lo;
        in_alu_result = t.alu;
        in_mem_rdata  = t.rdata;
        in_pc_plus4   = t.pc4;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_regwrite"},  {63'd0, RegWrite}, 64'd0);
        check({tag, "_writeaddr"}, {59'd0, WriteAddr}, 64'd0);
        check({tag, "_writedata"}, {32'd0, WriteData}, 64'd0);
        check({tag, "_wb_valid"},  {63'd0, wb_valid}, 64'd0);
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        vec_t t;
        //               v  rw rd     sel    f3      alo   alu           rdata pc4          rw  data
        vecs[0]  = mk(1, 1, 5'd5,  2'b00, 3'b000, 2'd0, 32'h1234_5678, RD, 32'h0,        1, 32'h1234_5678);
        vecs[1]  = mk(1, 1, 5'd10, 2'b01, 3'b000, 2'd3, 32'h0,         RD, 32'h0,        1, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 1, 5'd11, 2'b01, 3'b100, 2'd2, 32'h0,         RD, 32'h0,        1, 32'h0000_00FF);
        vecs[3]  = mk(1, 1, 5'd12, 2'b01, 3'b001, 2'd2, 32'h0,         RD, 32'h0,        1, 32'hFFFF_80FF);
        vecs[4]  = mk(1, 1, 5'd13, 2'b01, 3'b101, 2'd0, 32'h0,         RD, 32'h0,        1, 32'h0000_7F01);
        vecs[5]  = mk(1, 1, 5'd14, 2'b01, 3'b000, 2'd1, 32'h0,         RD, 32'h0,        1, 32'h0000_007F);
        vecs[6]  = mk(1, 1, 5'd15, 2'b01, 3'b010, 2'd0, 32'h0,         RD, 32'h0,        1, 32'h80FF_7F01);
        vecs[7]  = mk(1, 1, 5'd0,  2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, RD, 32'h0,        0, 32'hDEAD_BEEF);
        vecs[8]  = mk(1, 1, 5'd1,  2'b10, 3'b000, 2'd0, 32'h5555_0000, RD, 32'h0000_0104, 1, 32'h0000_0104);
        vecs[9]  = mk(1, 1, 5'd2,  2'b11, 3'b000, 2'd0, 32'hCAFE_0001, RD, 32'h0000_0200, 1, 32'hCAFE_0001);
        vecs[10] = mk(0, 1, 5'd3,  2'b00, 3'b000, 2'd0, 32'h0000_0033, RD, 32'h0,        0, 32'h0000_0033);
        vecs[11] = mk(1, 0, 5'd4,  2'b00, 3'b000, 2'd0, 32'h0000_0044, RD, 32'h0,        0, 32'h0000_0044);
        vecs[12] = mk(1, 1, 5'd16, 2'b01, 3'b001, 2'd3, 32'h0,         RD, 32'h0,        1, 32'hFFFF_80FF);
        vecs[13] = mk(1, 1, 5'd17, 2'b01, 3'b011, 2'd1, 32'h0,         RD, 32'h0,        1, 32'h80FF_7F01);
        vecs[14] = mk(1, 1, 5'd18, 2'b01, 3'b100, 2'd0, 32'h0,         RD, 32'h0,        1, 32'h0000_0001);
        vecs[15] = mk(1, 1, 5'd31, 2'b01, 3'b101, 2'd2, 32'h0,         RD, 32'h0,        1, 32'h0000_80FF);

        // Reset held with random inputs.
        rst_n = 1'b0;
        stall = 1'($urandom);
        flush = 1'b0;
        in_valid      = 1'b1;
        in_reg_write  = 1'b1;
        in_rd         = 5'($urandom_range(1, 31));
        in_wb_sel     = 2'($urandom);
        in_funct3     = 3'($urandom);
        in_addr_lo    = 2'($urandom);
        in_alu_result = $urandom;
        in_mem_rdata  = $urandom;
        in_pc_plus4   = $urandom;
        repeat (3) @(negedge clk);
        check_zero("reset");
        stall = 1'b0;
        rst_n = 1'b1;

        // Table vectors: each captured on one edge, observed on the next negedge.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("vec%0d_regwrite", i), {63'd0, RegWrite}, {63'd0, vecs[i].exp_rw});
            check($sformatf("vec%0d_writeaddr", i), {59'd0, WriteAddr}, {59'd0, vecs[i].rd});
            check($sformatf("vec%0d_writedata", i), {32'd0, WriteData}, {32'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_wb_valid", i), {63'd0, wb_valid}, {63'd0, vecs[i].valid});
        end

        // Stall holds rd=7/0xA across three cycles while inputs move to rd=8.
        t = mk(1, 1, 5'd7, 2'b00, 3'b000, 2'd0, 32'h0000_000A, RD, 32'h0, 1, 32'h0);
        drive(t);
        step();
        check("stall_pre_addr", {59'd0, WriteAddr}, 64'd7);
        stall = 1'b1;
        in_rd = 5'd8;
        in_alu_result = 32'h0000_000B;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d_regwrite", c), {63'd0, RegWrite}, 64'd1);
            check($sformatf("stall%0d_addr", c), {59'd0, WriteAddr}, 64'd7);
            check($sformatf("stall%0d_data", c), {32'd0, WriteData}, 64'hA);
        end
        stall = 1'b0;
        step();
        check("unstall_addr", {59'd0, WriteAddr}, 64'd8);
        check("unstall_data", {32'd0, WriteData}, 64'hB);

        // Flush wins over stall.
        t = mk(1, 1, 5'd9, 2'b00, 3'b000, 2'd0, 32'h0000_000C, RD, 32'h0, 1, 32'h0);
        drive(t);
        flush = 1'b1;
        stall = 1'b1;
        step();
        check_zero("flush_stall");
        flush = 1'b0;
        stall = 1'b0;
        step();
        check("post_flush_addr", {59'd0, WriteAddr}, 64'd9);

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        check("retire_after_reset", retire_cnt, 64'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            stall    = (c == 3 || c == 4);
            flush    = (c == 8);
            in_valid = (c != 11);
            step();
        end
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("retire_cnt", retire_cnt, 64'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
